// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment encodings are active-low, bit 0 = segment a.
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG7_BLANK = 7'h7F;

    // Index = hex nibble value; entries are gfedcba, active-low.
    localparam seg7_t SEG7_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG7_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered load port.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int DWELL  = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  loadValid,
    input  logic [4*DIGITS-1:0]   loadData,
    output logic                  loadReady,
    output logic [6:0]            segmentOutput,
    output logic [DIGITS-1:0]     digitSelect,
    output logic                  frameDone
);

    localparam int CW = $clog2(DWELL);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [4*DIGITS-1:0] displayReg;
    logic [4*DIGITS-1:0] shadowReg;
    logic                pendingReg;
    logic [IW-1:0]       idxReg;
    logic [CW-1:0]       cntReg;
    logic [6:0]          segReg;
    logic [DIGITS-1:0]   selReg;
    logic                doneReg;

    logic [6:0]          segNext;
    logic [DIGITS-1:0]   selNext;
    logic [6:0]          decoded;
    logic [3:0]          digitNibble [DIGITS];
    logic                dwellEnd;
    logic                frameEnd;
    logic                transfer;

    assign dwellEnd  = (cntReg == CNT_LAST);
    assign frameEnd  = dwellEnd && (idxReg == IDX_LAST);
    assign loadReady = !pendingReg;
    assign transfer  = loadValid && !pendingReg;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
        assign digitNibble[gi] = displayReg[4*gi +: 4];
    end

    seg7_decode u_decode (
        .nibble   (digitNibble[idxReg]),
        .segments (decoded)
    );

`ifdef SEG7_LZB_EN
    // leadZero[i]: nibbles i..DIGITS-1 of the committed value are all zero.
    logic [DIGITS-1:0] leadZero;
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lead
        assign leadZero[gi] = (displayReg[4*DIGITS-1:4*gi] == '0);
    end
`endif

    always_comb begin
        segNext         = decoded;
        selNext         = '1;
        selNext[idxReg] = 1'b0;
`ifdef SEG7_LZB_EN
        if (idxReg != '0 && leadZero[idxReg]) begin
            segNext = SEG7_BLANK;
        end
`endif
        // Dark for one cycle at every digit change so the old pattern never
        // bleeds onto the next digit.
        if (dwellEnd) begin
            segNext = SEG7_BLANK;
            selNext = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            displayReg <= '0;
            shadowReg  <= '0;
            pendingReg <= 1'b0;
            idxReg     <= '0;
            cntReg     <= '0;
            segReg     <= SEG7_BLANK;
            selReg     <= '1;
            doneReg    <= 1'b0;
        end else begin
            segReg  <= segNext;
            selReg  <= selNext;
            doneReg <= frameEnd;

            if (dwellEnd) begin
                cntReg <= '0;
                idxReg <= (idxReg == IDX_LAST) ? '0 : idxReg + IW'(1);
            end else begin
                cntReg <= cntReg + CW'(1);
            end

            // Transfer and commit are mutually exclusive: one needs pending
            // clear, the other needs it set.
            if (transfer) begin
                shadowReg  <= loadData;
                pendingReg <= 1'b1;
            end else if (frameEnd && pendingReg) begin
                displayReg <= shadowReg;
                pendingReg <= 1'b0;
            end
        end
    end

    assign segmentOutput = segReg;
    assign digitSelect   = selReg;
    assign frameDone     = doneReg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (DIGITS=8, DWELL=4) with a frame-position reference model.
module tb_seg7_scan_ctrl;

    localparam int DIGITS = 8;
    localparam int DWELL  = 4;
    localparam int FRAME  = DIGITS * DWELL;
`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        loadValid = 1'b0;
    logic [31:0] loadData = '0;
    logic        loadReady;
    logic [6:0]  segmentOutput;
    logic [7:0]  digitSelect;
    logic        frameDone;

    seg7_scan_ctrl #(.DIGITS(DIGITS), .DWELL(DWELL)) dut (
        .clk           (clk),
        .reset         (reset),
        .loadValid     (loadValid),
        .loadData      (loadData),
        .loadReady     (loadReady),
        .segmentOutput (segmentOutput),
        .digitSelect   (digitSelect),
        .frameDone     (frameDone)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    logic [6:0] segTab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: position within the frame plus the buffered values.
    int          mPos = 0;
    bit          mPending = 0;
    logic [31:0] mShadow = '0;
    logic [31:0] mDisplay = '0;
    logic [6:0]  expSeg = 7'h7F;
    logic [7:0]  expSel = 8'hFF;
    logic        expDone = 1'b0;
    logic        expReady = 1'b1;

    task automatic tick();
        int digit;
        bit ghost;
        bit blankd;
        logic [31:0] upper;
        @(posedge clk);
        if (reset) begin
            mPos = 0; mPending = 0; mShadow = '0; mDisplay = '0;
            expSeg = 7'h7F; expSel = 8'hFF; expDone = 1'b0;
        end else begin
            digit  = mPos / DWELL;
            ghost  = (mPos % DWELL) == DWELL - 1;
            upper  = mDisplay >> (4 * digit);
            blankd = LZB && digit != 0 && upper == 0;
            expSeg = ghost ? 7'h7F : (blankd ? 7'h7F : segTab[upper[3:0]]);
            expSel = ghost ? 8'hFF : ~(8'h01 << digit);
            expDone = (mPos == FRAME - 1);
            if (mPos == FRAME - 1 && mPending) begin
                mDisplay = mShadow;
                mPending = 0;
            end else if (loadValid && !mPending) begin
                mShadow  = loadData;
                mPending = 1;
            end
            mPos = (mPos + 1) % FRAME;
        end
        expReady = !mPending;
        #1;
    endtask

    // Advance until the cycle where frameDone is high; a missing pulse is a failure.
    task automatic sync_frame();
        bit seen = 0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            tick();
            if (frameDone === 1'b1) seen = 1;
        end
        testsRun++;
        if (!seen) begin
            testsFailed++;
            $display("FAIL sync_frame: frameDone got none within %0d cycles, expected a pulse", 2 * FRAME);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if ({segmentOutput, digitSelect, frameDone, loadReady} !== {7'h7F, 8'hFF, 1'b0, 1'b1}) begin
                testsFailed++;
                $display("FAIL reset_hold: got seg=%h sel=%h done=%b ready=%b expected seg=7f sel=ff done=0 ready=1",
                         segmentOutput, digitSelect, frameDone, loadReady);
            end
        end
        reset = 1'b0;
        tick();
        testsRun++;
        if (digitSelect !== 8'hFE || segmentOutput !== 7'h40) begin
            testsFailed++;
            $display("FAIL reset_first: got sel=%h seg=%h expected sel=fe seg=40", digitSelect, segmentOutput);
        end
    endtask

    task automatic test_load_commit();
        for (int i = 0; i < 5; i++) tick();
        loadValid = 1'b1; loadData = 32'h1234ABCD;
        tick();
        loadValid = 1'b0;
        testsRun++;
        if (loadReady !== 1'b0) begin
            testsFailed++;
            $display("FAIL load_ready_low: got %b expected 0", loadReady);
        end
        sync_frame();
        testsRun++;
        if (loadReady !== 1'b1) begin
            testsFailed++;
            $display("FAIL load_ready_back: got %b expected 1", loadReady);
        end
        tick();
        testsRun++;
        if (segmentOutput !== 7'h21 || digitSelect !== 8'hFE) begin
            testsFailed++;
            $display("FAIL commit_digit0: got seg=%h sel=%h expected seg=21 sel=fe", segmentOutput, digitSelect);
        end
        for (int i = 0; i < 7 * DWELL; i++) tick();
        testsRun++;
        if (segmentOutput !== 7'h79 || digitSelect !== 8'h7F) begin
            testsFailed++;
            $display("FAIL commit_digit7: got seg=%h sel=%h expected seg=79 sel=7f", segmentOutput, digitSelect);
        end
    endtask

    task automatic test_back_pressure();
        sync_frame();
        loadValid = 1'b1; loadData = 32'h13572468;
        tick();
        loadData = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            testsRun++;
            if ({segmentOutput, digitSelect, frameDone, loadReady} !== {expSeg, expSel, expDone, expReady}) begin
                testsFailed++;
                $display("FAIL back_pressure_model: got seg=%h sel=%h done=%b ready=%b expected seg=%h sel=%h done=%b ready=%b",
                         segmentOutput, digitSelect, frameDone, loadReady, expSeg, expSel, expDone, expReady);
            end
        end
        loadValid = 1'b0;
        testsRun++;
        if (loadReady !== 1'b0) begin
            testsFailed++;
            $display("FAIL back_pressure_ready: got %b expected 0", loadReady);
        end
        for (int f = 0; f < 2; f++) begin
            sync_frame();
            tick();
            testsRun++;
            if (segmentOutput !== 7'h00 || digitSelect !== 8'hFE) begin
                testsFailed++;
                $display("FAIL back_pressure_shown f%0d: got seg=%h sel=%h expected seg=00 sel=fe",
                         f, segmentOutput, digitSelect);
            end
        end
    endtask

    task automatic test_frame_end_load();
        sync_frame();
        for (int i = 0; i < FRAME - 1; i++) begin
            tick();
            testsRun++;
            if ({segmentOutput, digitSelect, frameDone, loadReady} !== {expSeg, expSel, expDone, expReady}) begin
                testsFailed++;
                $display("FAIL frame_end_model: got seg=%h sel=%h done=%b ready=%b expected seg=%h sel=%h done=%b ready=%b",
                         segmentOutput, digitSelect, frameDone, loadReady, expSeg, expSel, expDone, expReady);
            end
        end
        loadValid = 1'b1; loadData = 32'h00000009;
        tick();
        loadValid = 1'b0;
        testsRun++;
        if (frameDone !== 1'b1 || loadReady !== 1'b0) begin
            testsFailed++;
            $display("FAIL frame_end_xfer: got done=%b ready=%b expected done=1 ready=0", frameDone, loadReady);
        end
        tick();
        testsRun++;
        if (segmentOutput !== 7'h00) begin
            testsFailed++;
            $display("FAIL frame_end_no_commit: got seg=%h expected 00", segmentOutput);
        end
        sync_frame();
        tick();
        testsRun++;
        if (segmentOutput !== 7'h18) begin
            testsFailed++;
            $display("FAIL frame_end_next_commit: got seg=%h expected 18", segmentOutput);
        end
    endtask

    task automatic test_ghost_wrap();
        logic [7:0] wantSel;
        logic       wantDone;
        sync_frame();
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            wantSel  = (k % DWELL == DWELL - 1) ? 8'hFF : ~(8'h01 << ((k / DWELL) % DIGITS));
            wantDone = (k % FRAME == FRAME - 1);
            testsRun++;
            if (digitSelect !== wantSel || frameDone !== wantDone) begin
                testsFailed++;
                $display("FAIL ghost_wrap k=%0d: got sel=%h done=%b expected sel=%h done=%b",
                         k, digitSelect, frameDone, wantSel, wantDone);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            loadValid = ($urandom_range(0, 5) == 0);
            loadData  = $urandom;
            tick();
            testsRun++;
            if ({segmentOutput, digitSelect, frameDone, loadReady} !== {expSeg, expSel, expDone, expReady}) begin
                testsFailed++;
                $display("FAIL random i=%0d: got seg=%h sel=%h done=%b ready=%b expected seg=%h sel=%h done=%b ready=%b",
                         i, segmentOutput, digitSelect, frameDone, loadReady, expSeg, expSel, expDone, expReady);
            end
        end
        loadValid = 1'b0;
    endtask

    task automatic test_reset_pending();
        sync_frame();
        loadValid = 1'b1; loadData = 32'h000000FF;
        tick();
        loadValid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        testsRun++;
        if (loadReady !== 1'b1 || segmentOutput !== 7'h7F) begin
            testsFailed++;
            $display("FAIL reset_pending: got ready=%b seg=%h expected ready=1 seg=7f", loadReady, segmentOutput);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            testsRun++;
            if ({segmentOutput, digitSelect, frameDone, loadReady} !== {expSeg, expSel, expDone, expReady}) begin
                testsFailed++;
                $display("FAIL reset_pending_model i=%0d: got seg=%h sel=%h expected seg=%h sel=%h",
                         i, segmentOutput, digitSelect, expSeg, expSel);
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] want;
        int d;
        sync_frame();
        loadValid = 1'b1; loadData = 32'h00000050;
        tick();
        loadValid = 1'b0;
        sync_frame();
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (k % DWELL != DWELL - 1) begin
                d = k / DWELL;
                if (d == 1)      want = 7'h12;
                else if (d == 0) want = 7'h40;
                else             want = LZB ? 7'h7F : 7'h40;
                testsRun++;
                if (segmentOutput !== want || digitSelect !== ~(8'h01 << d)) begin
                    testsFailed++;
                    $display("FAIL blanking digit %0d: got seg=%h sel=%h expected seg=%h sel=%h",
                             d, segmentOutput, digitSelect, want, ~(8'h01 << d));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_commit();
        test_back_pressure();
        test_frame_end_load();
        test_ghost_wrap();
        test_random();
        test_reset_pending();
        test_blanking();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
